// File: rtl/abs_sample_feeder.sv
// rtl/abs_sample_feeder.sv - sample-to-magnitude frame assembler for the threshold integrator
// Builds 8-channel saturated-magnitude frames and raises the sample_core_done setup handshake.
module abs_sample_feeder #(
  parameter int          WARMUP_FRAMES = 2,
  parameter logic [31:0] TIMEOUT       = 32'd4096
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         enable,
  input  logic [15:0]  s_data,
  input  logic [2:0]   s_chan,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [119:0] abs_value_out_concat,
  output logic [7:0]   value_ready_concat,
  output logic         sample_core_done,
  output logic         err_order,
  output logic         err_timeout,
  output logic         sat_flag
);

  typedef enum logic [1:0] {IDLE, SETUP, RUNNING, ERROR} state_t;

  localparam logic [7:0] WARMUP8 = 8'(WARMUP_FRAMES);

  state_t        state;
  logic [104:0]  staging;
  logic [2:0]    exp_ch;
  logic [7:0]    frame_cnt;
  logic [31:0]   timer;

  logic          beat;
  logic          in_order;
  logic          commit;
  logic          timer_hit;
  logic          is_min;
  logic [14:0]   abs_val;

  assign s_ready = (state == SETUP) || (state == RUNNING);

  always_comb begin
    beat      = s_valid && s_ready;
    in_order  = (s_chan == exp_ch);
    commit    = beat && enable && in_order && (exp_ch == 3'd7);
    timer_hit = (state == RUNNING) && (TIMEOUT != 32'd0) && (timer == TIMEOUT);
    is_min    = (s_data == 16'h8000);
    // -32768 has no positive twin in 16 bits, so it clips to the largest magnitude
    if (is_min)
      abs_val = 15'h7FFF;
    else if (s_data[15])
      abs_val = 15'(~s_data[14:0] + 15'd1);
    else
      abs_val = s_data[14:0];
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state                <= IDLE;
      staging              <= '0;
      exp_ch               <= 3'd0;
      frame_cnt            <= 8'd0;
      timer                <= 32'd0;
      abs_value_out_concat <= '0;
      value_ready_concat   <= 8'd0;
      sample_core_done     <= 1'b0;
      err_order            <= 1'b0;
      err_timeout          <= 1'b0;
      sat_flag             <= 1'b0;
    end else begin
      value_ready_concat <= 8'd0;
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= SETUP;
            exp_ch <= 3'd0;
          end
        end
        SETUP, RUNNING: begin
          if (!enable) begin
            state            <= IDLE;
            exp_ch           <= 3'd0;
            frame_cnt        <= 8'd0;
            timer            <= 32'd0;
            sample_core_done <= 1'b0;
          end else begin
            if (state == RUNNING)
              timer <= commit ? 32'd0 : timer + 32'd1;
            if (beat) begin
              exp_ch <= exp_ch + 3'd1;
              if (!in_order) begin
                err_order <= 1'b1;
                state     <= ERROR;
              end else begin
                if (is_min)
                  sat_flag <= 1'b1;
                for (int c = 0; c < 7; c++)
                  if (exp_ch == 3'(c))
                    staging[c*15 +: 15] <= abs_val;
                if (commit) begin
                  abs_value_out_concat <= {abs_val, staging};
                  value_ready_concat   <= 8'hFF;
                  frame_cnt            <= (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
                  if (state == SETUP && (frame_cnt + 8'd1) == WARMUP8) begin
                    sample_core_done <= 1'b1;
                    state            <= RUNNING;
                    timer            <= 32'd0;
                  end
                end
              end
            end
            // a commit at the deadline edge still counts as on time
            if (timer_hit && !commit) begin
              err_timeout <= 1'b1;
              state       <= ERROR;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_abs_sample_feeder.sv
// tb/tb_abs_sample_feeder.sv - scoreboard bench for abs_sample_feeder
// Driver updates a frame-level model and queues expected commits; a negedge monitor checks them.
module tb_abs_sample_feeder;

  localparam int WARM = 2;
  localparam int TMO  = 50;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         enable;
  logic [15:0]  s_data;
  logic [2:0]   s_chan;
  logic         s_valid;
  logic         s_ready;
  logic [119:0] abs_value_out_concat;
  logic [7:0]   value_ready_concat;
  logic         sample_core_done;
  logic         err_order;
  logic         err_timeout;
  logic         sat_flag;

  abs_sample_feeder #(.WARMUP_FRAMES(WARM), .TIMEOUT(32'(TMO))) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .s_data(s_data), .s_chan(s_chan), .s_valid(s_valid), .s_ready(s_ready),
    .abs_value_out_concat(abs_value_out_concat), .value_ready_concat(value_ready_concat),
    .sample_core_done(sample_core_done), .err_order(err_order),
    .err_timeout(err_timeout), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [119:0] bus;
    logic         done;
  } frame_t;

  frame_t       exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           exp_m;
  int           frames_m;
  int           stage_m[8];
  logic [119:0] bus_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [119:0] act, input logic [119:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ref_abs(input logic signed [15:0] x);
    int v;
    v = x;
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // Monitor: every strobe cycle consumes one expected frame
  always @(negedge clk) begin
    if (aresetn && value_ready_concat !== 8'h00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {112'd0, value_ready_concat}, 120'd0);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        chk("strobe", {112'd0, value_ready_concat}, {112'd0, 8'hFF});
        chk("frame_bus", abs_value_out_concat, f.bus);
        chk("done_at_strobe", {119'd0, sample_core_done}, {119'd0, f.done});
      end
    end
  end

  task automatic model_clear();
    exp_m    = 0;
    frames_m = 0;
    for (int i = 0; i < 8; i++) stage_m[i] = 0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'd0;
    s_chan  = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    model_clear();
    bus_m = '0;
    exp_q.delete();
  endtask

  task automatic go_enable();
    enable = 1'b1;
    exp_m  = 0;
    frames_m = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic [2:0] c);
    int   tries;
    logic ok;
    frame_t f;
    tries   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_chan  = c;
    do begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 50);
    if (!ok) begin
      chk("beat_accept", 120'd0, 120'd1);
    end else if (enable) begin
      if (int'(c) != exp_m) begin
        exp_m = 8;
      end else begin
        stage_m[c] = ref_abs(d);
        exp_m = (exp_m + 1) % 8;
        if (c == 3'd7) begin
          for (int i = 0; i < 8; i++) f.bus[15*i +: 15] = 15'(stage_m[i]);
          frames_m++;
          f.done = (frames_m >= WARM);
          bus_m  = f.bus;
          exp_q.push_back(f);
        end
      end
    end
  endtask

  function automatic logic [15:0] rand_sample();
    case ($urandom_range(0, 9))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_data  = 16'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    int c0, s_cyc, seen;
    logic [15:0] basic [8];
    basic = '{16'd100, -16'sd100, 16'd0, 16'd32767, -16'sd32767, -16'sd1, 16'd5, -16'sd5};

    do_reset();
    chk("reset_s_ready", {119'd0, s_ready}, 120'd0);
    chk("reset_bus", abs_value_out_concat, 120'd0);
    chk("reset_strobe", {112'd0, value_ready_concat}, 120'd0);
    chk("reset_flags", {116'd0, sample_core_done, err_order, err_timeout, sat_flag}, 120'd0);

    go_enable();
    chk("s_ready_after_enable", {119'd0, s_ready}, 120'd1);

    // basic frame followed immediately by a saturating frame: 16 beats, 16 cycles
    c0 = cyc;
    for (int i = 0; i < 8; i++) beat(basic[i], 3'(i));
    chk("sat_after_basic", {119'd0, sat_flag}, 120'd0);
    for (int i = 0; i < 8; i++) beat((i == 3) ? 16'h8000 : rand_sample(), 3'(i));
    chk("no_stall_16_beats", 120'(cyc - c0), 120'd16);
    chk("sat_after_min", {119'd0, sat_flag}, 120'd1);

    // randomized frames with short gaps, well inside the starvation limit
    for (int f = 0; f < 30; f++)
      for (int i = 0; i < 8; i++) begin
        idle($urandom_range(0, 2));
        beat(rand_sample(), 3'(i));
      end
    chk("sat_sticky", {119'd0, sat_flag}, 120'd1);
    chk("done_running", {119'd0, sample_core_done}, 120'd1);

    // commit landing on the deadline edge wins over the timeout
    s_cyc = cyc;
    s_valid = 1'b0;
    while (cyc < s_cyc + TMO - 7) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 8; i++) beat(rand_sample(), 3'(i));
    chk("commit_beats_timeout", {119'd0, err_timeout}, 120'd0);

    // starvation: timeout flag rises TMO+1 cycles after the last strobe cycle
    s_cyc = cyc;
    s_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && seen == 0; k++) begin
      @(negedge clk);
      if (err_timeout) seen = cyc;
    end
    chk("timeout_latency", 120'(seen - s_cyc), 120'(TMO + 1));
    chk("s_ready_in_error", {119'd0, s_ready}, 120'd0);

    // order error: one good frame, then channels 0,1,3 (the 3 carrying -32768)
    do_reset();
    go_enable();
    for (int i = 0; i < 8; i++) beat(16'(i * 1000 - 3000), 3'(i));
    beat(16'd7, 3'd0);
    beat(16'd8, 3'd1);
    beat(16'h8000, 3'd3);
    chk("err_order_next", {119'd0, err_order}, 120'd1);
    chk("s_ready_after_order", {119'd0, s_ready}, 120'd0);
    s_chan = 3'd2;
    repeat (5) @(negedge clk);
    chk("bus_frozen", abs_value_out_concat, bus_m);
    chk("sat_not_from_discard", {119'd0, sat_flag}, 120'd0);
    chk("err_order_sticky", {119'd0, err_order}, 120'd1);
    chk("err_timeout_clear", {119'd0, err_timeout}, 120'd0);
    do_reset();
    chk("recover_err_order", {119'd0, err_order}, 120'd0);
    chk("recover_bus", abs_value_out_concat, 120'd0);

    // enable drop mid-frame, with a beat in the same cycle that must be discarded
    go_enable();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) beat(rand_sample(), 3'(i));
    for (int i = 0; i < 5; i++) beat(16'd1234, 3'(i));
    enable  = 1'b0;
    s_valid = 1'b1;
    s_chan  = 3'd5;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", {119'd0, s_ready}, 120'd0);
    chk("idle_done", {119'd0, sample_core_done}, 120'd0);
    chk("idle_bus_held", abs_value_out_concat, bus_m);
    @(posedge clk);
    #1;
    go_enable();
    for (int i = 0; i < 8; i++) beat(rand_sample(), 3'(i));
    idle(3);
    chk("reenable_no_err", {118'd0, err_order, err_timeout}, 120'd0);
    chk("scoreboard_drained", 120'(exp_q.size()), 120'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
